// File: rtl/plab5_mcore_mem_net_req_queued.sv
// Registered memory-request-to-network adapter for one core port.
// Picks a destination bank from programmable address boundaries, rewrites
// the opaque field with the source id, tags the domain bit, drops requests
// that touch the secure region from a normal-domain requester (reporting
// them on err_*), and queues accepted requests in a small FIFO that feeds
// the request network.
//
// Handshakes (in_* and out_*): a transfer happens on a rising clk edge where
// val and rdy are both high. val never waits on rdy. Once out_val is raised,
// out_val and its payload (out_ctrl/out_data) hold steady until the transfer.
module plab5_mcore_mem_net_req_queued #(
  parameter int p_net_src           = 0,
  parameter int p_num_banks         = 2,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_addr_nbits    = 32,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  parameter int p_inst_split        = 32'h4000,
  parameter int p_data_split        = 32'hc000,
  parameter int p_bank_shift        = 14,
  parameter int p_secure_base       = 32'h10000,
  parameter int p_check_en          = 1,
  parameter int p_depth             = 2,
  localparam int c_len_nbits = $clog2(p_mem_data_nbits/8),
  localparam int c_in_nbits  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + c_len_nbits,
  localparam int c_out_nbits = 2*p_net_srcdest_nbits + p_net_opaque_nbits + c_in_nbits + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        domain,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [c_in_nbits-1:0]       in_ctrl,
  input  logic [p_mem_data_nbits-1:0] in_data,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [c_out_nbits-1:0]      out_ctrl,
  output logic [p_mem_data_nbits-1:0] out_data,
  output logic                        err_val,
  output logic [p_mem_addr_nbits-1:0] err_addr,
  output logic [7:0]                  err_count
);

  localparam int c_ma        = p_mem_addr_nbits;
  localparam int c_mo        = p_mem_opaque_nbits;
  localparam int c_ns        = p_net_srcdest_nbits;
  localparam int c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_cnt_nbits = c_ptr_nbits + 1;

  localparam logic [c_ma-1:0]        c_inst_split  = c_ma'(p_inst_split);
  localparam logic [c_ma-1:0]        c_data_split  = c_ma'(p_data_split);
  localparam logic [c_ma-1:0]        c_secure_base = c_ma'(p_secure_base);
  localparam logic [c_ma-1:0]        c_last_bank   = c_ma'(p_num_banks - 1);
  localparam logic [c_ns-1:0]        c_src         = c_ns'(p_net_src);
  localparam logic [c_cnt_nbits-1:0] c_depth       = c_cnt_nbits'(p_depth);

  // Request fields, MSB first: {type, opaque, addr, len}
  logic [2:0]             req_type;
  logic [c_mo-1:0]        req_opaque;
  logic [c_ma-1:0]        req_addr;
  logic [c_len_nbits-1:0] req_len;

  assign req_len    = in_ctrl[c_len_nbits-1:0];
  assign req_addr   = in_ctrl[c_len_nbits +: c_ma];
  assign req_opaque = in_ctrl[c_len_nbits + c_ma +: c_mo];
  assign req_type   = in_ctrl[c_len_nbits + c_ma + c_mo +: 3];

  logic [c_ma-1:0] boundary;
  logic [c_ma-1:0] stripe;
  logic [c_ma-1:0] dest_wide;
  logic [c_ns-1:0] dest;

  assign boundary = mode ? c_data_split : c_inst_split;
  assign stripe   = (req_addr - boundary) >> p_bank_shift;
  assign dest     = dest_wide[c_ns-1:0];

  // Bank select: bank 0 below the split, then one bank per stripe, with the
  // last bank absorbing everything above.
  always_comb begin
    dest_wide = '0;
    if (p_num_banks > 1 && req_addr >= boundary) begin
      if (stripe >= c_last_bank) dest_wide = c_last_bank;
      else                       dest_wide = stripe + c_ma'(1);
    end
  end

  logic [c_out_nbits-1:0] net_ctrl;
  assign net_ctrl = {dest, c_src, {p_net_opaque_nbits{1'b0}}, ~c_src[0],
                     req_type, c_src, req_opaque[c_mo-c_ns-1:0], req_addr, req_len};

  logic unused_bits;
  assign unused_bits = ^{dest_wide[c_ma-1:c_ns], req_opaque[c_mo-1:c_mo-c_ns]};

  logic [c_ptr_nbits-1:0] wr_ptr;
  logic [c_ptr_nbits-1:0] rd_ptr;
  logic [c_cnt_nbits-1:0] count;
  logic                   accept;
  logic                   reject;
  logic                   enq;
  logic                   deq;

  // A secure-region hit from the normal domain still completes the handshake
  // so the requester is never stuck; it just never reaches the network.
  assign in_rdy  = reset && (count < c_depth);
  assign accept  = in_val && in_rdy;
  assign reject  = accept && (p_check_en != 0) && !domain && (req_addr >= c_secure_base);
  assign enq     = accept && !reject;
  assign out_val = (count != '0);
  assign deq     = out_val && out_rdy;

  logic [c_out_nbits-1:0]      ctrl_q [p_depth];
  logic [p_mem_data_nbits-1:0] data_q [p_depth];

  // Payload storage; contents are only visible while the entry is counted.
  always_ff @(posedge clk) begin
    if (enq) begin
      ctrl_q[wr_ptr] <= net_ctrl;
      data_q[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; reset flushes every queued entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + c_ptr_nbits'(1);
      if (deq) rd_ptr <= rd_ptr + c_ptr_nbits'(1);
      case ({enq, deq})
        2'b10:   count <= count + c_cnt_nbits'(1);
        2'b01:   count <= count - c_cnt_nbits'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_ctrl = out_val ? ctrl_q[rd_ptr] : '0;
  assign out_data = out_val ? data_q[rd_ptr] : '0;

  // Rejection reporting: one-cycle pulse, last address, saturating count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_val   <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      err_val <= reject;
      if (reject) err_addr <= req_addr;
      if (reject && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_net_req_queued.sv
// Directed bench for plab5_mcore_mem_net_req_queued (p_net_src=5, 4 banks).
// out_ctrl layout: [55:53] dest, [52:50] src, [49:46] net opaque,
// [45] dom bit, [44:42] type, [41:34] opaque', [33:2] addr, [1:0] len.
module tb_plab5_mcore_mem_net_req_queued;

  localparam int MA = 32;
  localparam int MD = 32;
  localparam int CW = 45;
  localparam int OW = 56;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic          domain;
  logic          in_val;
  logic          in_rdy;
  logic [CW-1:0] in_ctrl;
  logic [MD-1:0] in_data;
  logic          out_val;
  logic          out_rdy;
  logic [OW-1:0] out_ctrl;
  logic [MD-1:0] out_data;
  logic          err_val;
  logic [MA-1:0] err_addr;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW+MD-1:0] exp_q[$];

  plab5_mcore_mem_net_req_queued #(
    .p_net_src   (5),
    .p_num_banks (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .domain    (domain),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .err_val   (err_val),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected network control word for core 5 (dom bit = ~5[0] = 0)
  function automatic logic [OW-1:0] pack_net(input logic [2:0] dest, input logic [2:0] typ,
                                             input logic [7:0] opq, input logic [31:0] addr,
                                             input logic [1:0] len);
    return {dest, 3'd5, 4'd0, 1'b0, typ, 3'd5, opq[4:0], addr, len};
  endfunction

  // Driver: present one request, hold it until accepted, then drop in_val.
  task automatic send(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                      input logic [1:0] len, input logic [31:0] data,
                      input logic fwd, input logic [2:0] dest);
    int waited;
    waited  = 0;
    in_val  = 1'b1;
    in_ctrl = {typ, opq, addr, len};
    in_data = data;
    @(negedge clk);
    while (!in_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send_accept", in_rdy, 1'b1);
    if (in_rdy && fwd) exp_q.push_back({pack_net(dest, typ, opq, addr, len), data});
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_val) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", (exp_q.size() == 0) && !out_val, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    in_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Scoreboard: every network transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_val, 1'b0);
      end else begin
        logic [OW+MD-1:0] e;
        e = exp_q.pop_front();
        check("out_ctrl", out_ctrl, e[OW+MD-1:MD]);
        check("out_data", out_data, e[MD-1:0]);
      end
    end
  end

  initial begin
    reset   = 1'b0;
    mode    = 1'b0;
    domain  = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    in_ctrl = '0;
    in_data = '0;

    // Reset state
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_rdy", in_rdy, 1'b0);
    check("rst_out_val", out_val, 1'b0);
    check("rst_err_val", err_val, 1'b0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_err_count", err_count, 8'h0);
    check("rst_out_ctrl", out_ctrl, 56'h0);
    check("rst_out_data", out_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_rdy", in_rdy, 1'b1);
    check("post_rst_out_val", out_val, 1'b0);
    @(posedge clk);
    #1;

    // Inst mode, just below the split -> bank 0, one-cycle latency
    out_rdy = 1'b1;
    send(3'd1, 8'h13, 32'h3ffc, 2'd0, 32'h1111_2222, 1'b1, 3'd0);
    @(negedge clk);
    check("t1_out_val", out_val, 1'b1);
    check("t1_dest", out_ctrl[55:53], 3'd0);
    check("t1_src", out_ctrl[52:50], 3'd5);
    check("t1_net_opq", out_ctrl[49:46], 4'd0);
    check("t1_dom", out_ctrl[45], 1'b0);
    check("t1_opq_top", out_ctrl[41:39], 3'd5);
    check("t1_err_val", err_val, 1'b0);
    @(posedge clk);
    #1;
    wait_drain();

    // Data mode, four banks, saturating at the last bank
    mode   = 1'b1;
    domain = 1'b1;
    do_reset();
    out_rdy = 1'b1;
    send(3'd1, 8'h41, 32'h0000_bffc, 2'd3, 32'ha0a0_0001, 1'b1, 3'd0);
    send(3'd1, 8'h42, 32'h0000_c000, 2'd3, 32'ha0a0_0002, 1'b1, 3'd1);
    send(3'd0, 8'h43, 32'h0001_0000, 2'd0, 32'ha0a0_0003, 1'b1, 3'd2);
    send(3'd0, 8'h44, 32'h0004_0000, 2'd1, 32'ha0a0_0004, 1'b1, 3'd3);
    wait_drain();

    // Backpressure: depth 2 fills, third request waits, head stays stable
    out_rdy = 1'b0;
    send(3'd0, 8'h21, 32'h0000_0100, 2'd2, 32'hb0b0_0001, 1'b1, 3'd0);
    send(3'd1, 8'h22, 32'h0000_d000, 2'd3, 32'hb0b0_0002, 1'b1, 3'd1);
    in_val  = 1'b1;
    in_ctrl = {3'd1, 8'h23, 32'h0001_3ffc, 2'd1};
    in_data = 32'hb0b0_0003;
    @(negedge clk);
    check("full_in_rdy", in_rdy, 1'b0);
    check("stall_out_val", out_val, 1'b1);
    check("stall_head_ctrl", out_ctrl, pack_net(3'd0, 3'd0, 8'h21, 32'h0000_0100, 2'd2));
    check("stall_head_data", out_data, 32'hb0b0_0001);
    @(negedge clk);
    check("stall_in_rdy_2", in_rdy, 1'b0);
    check("stall_head_hold", out_ctrl, pack_net(3'd0, 3'd0, 8'h21, 32'h0000_0100, 2'd2));
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    send(3'd1, 8'h23, 32'h0001_3ffc, 2'd1, 32'hb0b0_0003, 1'b1, 3'd2);
    wait_drain();

    // Secure check: normal domain rejected, secure domain forwarded
    domain = 1'b0;
    send(3'd1, 8'h31, 32'h0001_0004, 2'd0, 32'hdead_beef, 1'b0, 3'd0);
    @(negedge clk);
    check("rej_err_val", err_val, 1'b1);
    check("rej_err_addr", err_addr, 32'h0001_0004);
    check("rej_err_count", err_count, 8'd1);
    check("rej_out_val", out_val, 1'b0);
    @(negedge clk);
    check("rej_pulse_end", err_val, 1'b0);
    @(posedge clk);
    #1;
    domain = 1'b1;
    send(3'd1, 8'h31, 32'h0001_0004, 2'd0, 32'hdead_beef, 1'b1, 3'd2);
    wait_drain();
    check("sec_err_count", err_count, 8'd1);

    // Saturation of err_count: 1 + 253 = 254, then 47 more -> 255
    domain = 1'b0;
    for (int i = 0; i < 253; i++)
      send(3'd0, 8'h00, 32'h0002_0000 + 32'(i * 4), 2'd0, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    check("sat_254", err_count, 8'd254);
    @(posedge clk);
    #1;
    for (int i = 0; i < 47; i++)
      send(3'd0, 8'h00, 32'h0003_0000 + 32'(i * 4), 2'd0, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    check("sat_255", err_count, 8'd255);
    check("sat_err_addr", err_addr, 32'h0003_00b8);
    check("sat_out_val", out_val, 1'b0);
    @(posedge clk);
    #1;

    // Reset with two entries queued
    domain  = 1'b1;
    out_rdy = 1'b0;
    send(3'd1, 8'h51, 32'h0000_0200, 2'd0, 32'hc0c0_0001, 1'b1, 3'd0);
    send(3'd1, 8'h52, 32'h0000_0300, 2'd0, 32'hc0c0_0002, 1'b1, 3'd0);
    @(negedge clk);
    check("pre_rst_out_val", out_val, 1'b1);
    check("pre_rst_in_rdy", in_rdy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_val", out_val, 1'b0);
    check("mid_rst_err_count", err_count, 8'd0);
    check("mid_rst_err_addr", err_addr, 32'h0);
    check("mid_rst_in_rdy", in_rdy, 1'b0);
    check("mid_rst_out_ctrl", out_ctrl, 56'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset   = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    check("after_rst_in_rdy", in_rdy, 1'b1);
    check("after_rst_out_val", out_val, 1'b0);
    @(posedge clk);
    #1;
    send(3'd2, 8'hff, 32'h0000_0008, 2'd2, 32'h5555_aaaa, 1'b1, 3'd0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
